alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational integer ALU between two requesters
//   (0 = core execute path, 1 = auxiliary unit). Operations are accepted over
//   valid/ready with round-robin arbitration. The winner's ALUOp/funct is
//   decoded into the ALU's 3-bit control plus a subtract flag. Operands and
//   control are registered into the ALU, and the result returns on a single
//   response channel that carries the requester ID.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req_valid[1:0]  requester N has an operation pending
//   req_ready[1:0]  requester N granted this cycle (one-hot or zero)
//   req_aluop[5:0]  ALUOp of requester N at [3N+2:3N]
//   req_funct[7:0]  {funct7[5], funct3} of requester N at [4N+3:4N]
//   req_a, req_b    operands of requester N at [N*XLEN +: XLEN]
//   alu_ctrl/sub    registered ALU control and subtract flag
//   alu_a, alu_b    registered ALU operands
//   alu_y           combinational ALU result
//   rsp_valid/ready response handshake
//   rsp_id          requester that issued the response
//   rsp_data        captured ALU result
//   busy            arbiter is not idle
module alu_share_arbiter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [5:0]        req_aluop,
    input  logic [7:0]        req_funct,
    input  logic [2*XLEN-1:0] req_a,
    input  logic [2*XLEN-1:0] req_b,
    output logic [2:0]        alu_ctrl,
    output logic              alu_sub,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    input  logic [XLEN-1:0]   alu_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [XLEN-1:0]   rsp_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rr;
    logic        winner;
    logic        grant_ok;
    logic [1:0]  grant;
    logic [2:0]  win_aluop;
    logic [3:0]  win_funct;
    logic [3:0]  win_dec;

    // Returns {ctrl, sub}. Every encoding falls through to a defined value,
    // so the ALU never sees X.
    function automatic logic [3:0] decode(input logic [2:0] aluop, input logic [3:0] funct);
        logic [3:0] d;
        d = 4'b000_0;
        if (aluop == 3'b000 || aluop == 3'b001) begin
            case (funct[2:0])
                3'b000:  d = {3'b000, (aluop == 3'b000) & funct[3]};
                3'b001:  d = 4'b110_0;
                3'b010,
                3'b011:  d = 4'b001_1;
                3'b100:  d = 4'b100_0;
                3'b101:  d = funct[3] ? 4'b101_0 : 4'b111_0;
                3'b110:  d = 4'b011_0;
                default: d = 4'b010_0;
            endcase
        end else if (aluop == 3'b100) begin
            d = 4'b000_1;
        end
        return d;
    endfunction

    // Grants are possible in IDLE or in the response handshake cycle; held
    // off while reset is asserted so req_ready never pulses during reset.
    always_comb begin
        grant_ok  = rst_n && ((state == IDLE) || (state == RESP && rsp_ready));
        // Contention goes to rr; a lone requester always wins.
        winner    = (&req_valid) ? rr : ~req_valid[0];
        grant     = (grant_ok && (|req_valid)) ? (winner ? 2'b10 : 2'b01) : 2'b00;
        win_aluop = winner ? req_aluop[5:3] : req_aluop[2:0];
        win_funct = winner ? req_funct[7:4] : req_funct[3:0];
        win_dec   = decode(win_aluop, win_funct);
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|grant) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = (|grant) ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state and the grant.
    always_comb begin
        req_ready = grant;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    // Datapath: operands and control latch at grant and hold until the next
    // grant; the ALU result is captured during EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr       <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            alu_ctrl <= 3'b000;
            alu_sub  <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
        end else begin
            if (|grant) begin
                rr       <= ~winner;
                rsp_id   <= winner;
                alu_ctrl <= win_dec[3:1];
                alu_sub  <= win_dec[0];
                alu_a    <= winner ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
                alu_b    <= winner ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
            end
            if (state == EXEC) rsp_data <= alu_y;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Self-checking bench for alu_share_arbiter. The bench plays the external
//   ALU and both requesters. A transaction-level model (outstanding op, its
//   age, round-robin bit) predicts every output each cycle.
module tb_alu_share_arbiter;

    localparam int XLEN = 32;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [5:0]        req_aluop;
    logic [7:0]        req_funct;
    logic [2*XLEN-1:0] req_a;
    logic [2*XLEN-1:0] req_b;
    logic [2:0]        alu_ctrl;
    logic              alu_sub;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic [XLEN-1:0]   alu_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [XLEN-1:0]   rsp_data;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction model state.
    logic            busy_m;
    int              age;
    logic            rr_m;
    logic            pend_id;
    logic [XLEN-1:0] pend_y;
    logic [2:0]      last_ctrl;
    logic            last_sub;
    logic [XLEN-1:0] last_a;
    logic [XLEN-1:0] last_b;

    alu_share_arbiter #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_aluop (req_aluop),
        .req_funct (req_funct),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_ctrl  (alu_ctrl),
        .alu_sub   (alu_sub),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU semantics.
    function automatic logic [XLEN-1:0] alu_fn(input logic [2:0] c, input logic s,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (c)
            3'b000:  return s ? a - b : a + b;
            3'b001:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return $unsigned($signed(a) >>> b[4:0]);
            3'b110:  return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    assign alu_y = alu_fn(alu_ctrl, alu_sub, alu_a, alu_b);

    // Expected {ctrl, sub} from the instruction-set view of ALUOp/funct.
    function automatic logic [3:0] exp_decode(input logic [2:0] op, input logic [3:0] f);
        logic r_or_i;
        r_or_i = (op == 3'd0) || (op == 3'd1);
        if (op == 3'd4) return 4'b000_1;                       // branch compare
        if (!r_or_i)    return 4'b000_0;                       // address add
        case (f[2:0])
            3'd0: return {3'b000, (op == 3'd0) && f[3]};       // add / sub
            3'd1: return 4'b110_0;                             // sll
            3'd2: return 4'b001_1;                             // slt
            3'd3: return 4'b001_1;                             // sltu
            3'd4: return 4'b100_0;                             // xor
            3'd5: return f[3] ? 4'b101_0 : 4'b111_0;           // sra / srl
            3'd6: return 4'b011_0;                             // or
            default: return 4'b010_0;                          // and
        endcase
    endfunction

    task automatic model_reset();
        busy_m = 1'b0; age = 0; rr_m = 1'b0; pend_id = 1'b0; pend_y = '0;
        last_ctrl = 3'b000; last_sub = 1'b0; last_a = '0; last_b = '0;
    endtask

    // One clock: compare all outputs against the model at the falling edge,
    // advance the model across the rising edge, return with inputs free to
    // change (#1 after the edge). g reports the grant the model expected.
    task automatic step(output logic [1:0] g);
        logic       can;
        logic       w;
        logic [1:0] exp_rdy;
        logic [3:0] d;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        @(negedge clk);
        n_checks++;
        if (busy !== busy_m) begin
            n_fail++; $display("FAIL busy: got %b expected %b", busy, busy_m);
        end
        n_checks++;
        if ({alu_ctrl, alu_sub, alu_a, alu_b} !== {last_ctrl, last_sub, last_a, last_b}) begin
            n_fail++;
            $display("FAIL alu_out: got %b/%b/%h/%h expected %b/%b/%h/%h",
                     alu_ctrl, alu_sub, alu_a, alu_b, last_ctrl, last_sub, last_a, last_b);
        end
        n_checks++;
        if (rsp_valid !== (busy_m && age >= 2)) begin
            n_fail++; $display("FAIL rsp_valid: got %b expected %b", rsp_valid, busy_m && age >= 2);
        end
        if (busy_m && age >= 2) begin
            n_checks++;
            if (rsp_id !== pend_id || rsp_data !== pend_y) begin
                n_fail++;
                $display("FAIL rsp: got id %b data %h expected id %b data %h",
                         rsp_id, rsp_data, pend_id, pend_y);
            end
        end
        can     = !busy_m || (age >= 2 && rsp_ready);
        w       = (&req_valid) ? rr_m : !req_valid[0];
        exp_rdy = (can && (|req_valid)) ? (w ? 2'b10 : 2'b01) : 2'b00;
        n_checks++;
        if (req_ready !== exp_rdy) begin
            n_fail++; $display("FAIL req_ready: got %b expected %b", req_ready, exp_rdy);
        end
        g = exp_rdy;
        d = exp_decode(req_aluop[3*w +: 3], req_funct[4*w +: 4]);
        a = req_a[XLEN*w +: XLEN];
        b = req_b[XLEN*w +: XLEN];
        @(posedge clk);
        if (busy_m && age >= 2 && rsp_ready) busy_m = 1'b0;
        else if (busy_m)                     age++;
        if (exp_rdy != 2'b00) begin
            busy_m = 1'b1; age = 1; pend_id = w; rr_m = !w;
            last_ctrl = d[3:1]; last_sub = d[0]; last_a = a; last_b = b;
            pend_y = alu_fn(d[3:1], d[0], a, b);
        end
        #1;
    endtask

    task automatic set_req(input int n, input logic [2:0] op, input logic [3:0] f,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        req_aluop[3*n +: 3]    = op;
        req_funct[4*n +: 4]    = f;
        req_a[XLEN*n +: XLEN]  = a;
        req_b[XLEN*n +: XLEN]  = b;
    endtask

    task automatic rand_req(input int n);
        set_req(n, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom, $urandom);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        logic [1:0] g;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (3) step(g);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        rand_req(0);
        rand_req(1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, busy, alu_ctrl, alu_sub} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy %b rv %b busy %b ctrl %b sub %b expected all zero",
                     req_ready, rsp_valid, busy, alu_ctrl, alu_sub);
        end
        n_checks++;
        if (rsp_data !== '0 || rsp_id !== 1'b0 || alu_a !== '0 || alu_b !== '0) begin
            n_fail++; $display("FAIL reset_data: got data %h id %b a %h b %h expected zeros",
                               rsp_data, rsp_id, alu_a, alu_b);
        end
        req_valid = 2'b00;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single_sub();
        logic [1:0] g;
        rsp_ready = 1'b1;
        set_req(0, 3'b000, 4'b1000, 32'd10, 32'd3);
        req_valid = 2'b01;
        step(g);
        req_valid = 2'b00;
        n_checks++;
        if (alu_ctrl !== 3'b000 || alu_sub !== 1'b1) begin
            n_fail++; $display("FAIL sub_decode: got ctrl %b sub %b expected 000 1", alu_ctrl, alu_sub);
        end
        step(g);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd7) begin
            n_fail++; $display("FAIL sub_result: got v %b id %b data %0d expected 1 0 7",
                               rsp_valid, rsp_id, rsp_data);
        end
        drain();
    endtask

    task automatic test_contention();
        logic [1:0] g;
        logic [1:0] exp_g;
        apply_reset();
        rsp_ready = 1'b1;
        rand_req(0);
        rand_req(1);
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            step(g);
            exp_g = (i % 2 == 1) ? 2'b00 : (((i / 2) % 2 == 1) ? 2'b10 : 2'b01);
            n_checks++;
            if (req_ready !== 2'b00 && 1'b0) n_fail++;
            if (g !== exp_g) begin
                n_fail++; $display("FAIL contention_grant[%0d]: got %b expected %b", i, g, exp_g);
            end
            if (g[0]) rand_req(0);
            if (g[1]) rand_req(1);
            if (i % 2 == 1) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 1'(((i - 1) / 2) % 2)) begin
                    n_fail++; $display("FAIL contention_rsp[%0d]: got v %b id %b expected 1 %0d",
                                       i, rsp_valid, rsp_id, ((i - 1) / 2) % 2);
                end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [1:0] g;
        rsp_ready = 1'b0;
        set_req(0, 3'b000, 4'b0000, 32'd5, 32'd6);
        req_valid = 2'b01;
        step(g);
        req_valid = 2'b00;
        step(g);
        set_req(1, 3'b001, 4'b0100, 32'hF0, 32'h0F);
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step(g);
            n_checks++;
            if (g !== 2'b00 || rsp_data !== 32'd11 || rsp_valid !== 1'b1) begin
                n_fail++; $display("FAIL backpressure_hold[%0d]: got grant %b data %0d v %b expected 00 11 1",
                                   i, g, rsp_data, rsp_valid);
            end
        end
        rsp_ready = 1'b1;
        step(g);
        n_checks++;
        if (g !== 2'b10) begin
            n_fail++; $display("FAIL backpressure_regrant: got %b expected 10", g);
        end
        drain();
    endtask

    task automatic test_decode_sweep();
        logic [1:0] g;
        logic [2:0] ops [5]  = '{3'b000, 3'b001, 3'b100, 3'b010, 3'b000};
        logic [3:0] fns [5]  = '{4'b1101, 4'b0011, 4'b0000, 4'b0000, 4'b0101};
        logic [3:0] exps [5] = '{4'b101_0, 4'b001_1, 4'b000_1, 4'b000_0, 4'b111_0};
        logic [3:0] f;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            f = fns[i];
            if (ops[i] == 3'b100 || ops[i] == 3'b010) f = 4'($urandom_range(0, 15));
            set_req(1, ops[i], f, $urandom, 32'($urandom_range(0, 31)));
            req_valid = 2'b10;
            step(g);
            req_valid = 2'b00;
            n_checks++;
            if ({alu_ctrl, alu_sub} !== exps[i]) begin
                n_fail++; $display("FAIL decode[%0d] op %b funct %b: got %b expected %b",
                                   i, ops[i], f, {alu_ctrl, alu_sub}, exps[i]);
            end
            step(g);
            step(g);
        end
        drain();
    endtask

    task automatic test_reset_mid_exec();
        logic [1:0] g;
        rsp_ready = 1'b1;
        rand_req(1);
        req_valid = 2'b10;
        step(g);
        req_valid = 2'b11;
        rand_req(0);
        rand_req(1);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin
                n_fail++; $display("FAIL reset_mid_exec[%0d]: got v %b busy %b rdy %b expected 0 0 00",
                                   i, rsp_valid, busy, req_ready);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(g);
        n_checks++;
        if (g !== 2'b01) begin
            n_fail++; $display("FAIL reset_first_grant: got %b expected 01", g);
        end
        for (int i = 0; i < 6; i++) begin
            step(g);
            if (g[0]) rand_req(0);
            if (g[1]) rand_req(1);
        end
        drain();
    endtask

    task automatic test_random();
        logic [1:0] g;
        for (int i = 0; i < 400; i++) begin
            step(g);
            for (int n = 0; n < 2; n++) begin
                if (g[n] || !req_valid[n]) begin
                    req_valid[n] = ($urandom_range(0, 99) < 55);
                    rand_req(n);
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 60);
        end
        drain();
    endtask

    initial begin
        req_valid = 2'b00;
        req_aluop = '0;
        req_funct = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single_sub();
        test_contention();
        test_backpressure();
        test_decode_sweep();
        test_reset_mid_exec();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
